// File: rtl/sd_block_reader.sv
// Receive-side DAT0 engine for single-block SD reads in 1-bit mode: start bit, payload
// bytes to the sector cache, CRC16 and end-bit check, with a start-bit timeout.
module sd_block_reader #(
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned TIMEOUT_EDGES = 1000000,
  localparam int unsigned AW = $clog2(BLOCK_BYTES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sdclk,
  input  logic          sddat0,
  input  logic          rstart,
  output logic          rbusy,
  output logic          rdone,
  output logic          crc_ok,
  output logic          rtimeout,
  output logic [7:0]    rbyte,
  output logic          rbyte_we,
  output logic [AW-1:0] rbyte_addr,
  output logic          SD_D0_DIR
);

  localparam int unsigned BW = AW + 1;
  localparam int unsigned EW = $clog2(TIMEOUT_EDGES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CRC    = 3'd3;
  localparam logic [2:0] S_END    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]    state, state_nxt;
  logic          sdclk_l;
  logic          rise;
  logic          timeout_hit;
  logic [EW-1:0] edge_cnt;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [3:0]    crc_cnt;
  logic [6:0]    shreg;
  logic [7:0]    byte_nxt;
  logic [15:0]   crc, crc_nxt, rx_crc;
  logic          fb;

  // The card's DAT0 line is only ever an input to this block.
  assign SD_D0_DIR = 1'b0;

  // Edge detect, state transitions and the per-bit data path values.
  always_comb begin
    state_nxt   = state;
    rise        = sdclk & ~sdclk_l;
    timeout_hit = (edge_cnt == EW'(TIMEOUT_EDGES - 1));
    byte_nxt    = {shreg, sddat0};
    fb          = crc[15] ^ sddat0;
    crc_nxt     = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    case (state)
      S_IDLE:   if (rstart) state_nxt = S_WAIT;
      S_WAIT:   if (rise) begin
                  if (!sddat0)          state_nxt = S_DATA;
                  else if (timeout_hit) state_nxt = S_FINISH;
                end
      S_DATA:   if (rise && bit_cnt == 3'd7 && byte_cnt == BW'(BLOCK_BYTES - 1))
                  state_nxt = S_CRC;
      S_CRC:    if (rise && crc_cnt == 4'd15) state_nxt = S_END;
      S_END:    if (rise) state_nxt = S_FINISH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sdclk_l <= 1'b0;
    end else begin
      state   <= state_nxt;
      sdclk_l <= sdclk;
    end
  end

  // Registered outputs and receive data path; bit actions only on sdclk rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbusy      <= 1'b0;
      rdone      <= 1'b0;
      crc_ok     <= 1'b0;
      rtimeout   <= 1'b0;
      rbyte      <= 8'h00;
      rbyte_we   <= 1'b0;
      rbyte_addr <= '0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      crc_cnt    <= '0;
      shreg      <= '0;
      crc        <= '0;
      rx_crc     <= '0;
    end else begin
      rbyte_we <= 1'b0;
      rdone    <= (state == S_FINISH);
      rbusy    <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: if (rstart) begin
          crc_ok   <= 1'b0;
          rtimeout <= 1'b0;
          edge_cnt <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          crc_cnt  <= '0;
          crc      <= '0;
          rx_crc   <= '0;
        end
        S_WAIT: if (rise && sddat0) begin
          edge_cnt <= edge_cnt + EW'(1);
          if (timeout_hit) rtimeout <= 1'b1;
        end
        S_DATA: if (rise) begin
          shreg   <= {shreg[5:0], sddat0};
          crc     <= crc_nxt;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rbyte      <= byte_nxt;
            rbyte_we   <= 1'b1;
            rbyte_addr <= byte_cnt[AW-1:0];
            byte_cnt   <= byte_cnt + BW'(1);
          end
        end
        S_CRC: if (rise) begin
          rx_crc  <= {rx_crc[14:0], sddat0};
          crc_cnt <= crc_cnt + 4'd1;
        end
        S_END: if (rise) crc_ok <= (crc == rx_crc) && sddat0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_reader.sv
// Directed-sequence bench for sd_block_reader: random and fixed payloads against a
// bytewise CRC16 reference, timeout, mid-block rstart/reset and back-to-back blocks.
module tb_sd_block_reader;
  localparam int unsigned BB = 512;
  localparam int unsigned TO = 100;
  localparam int unsigned AW = $clog2(BB);

  logic          clk = 1'b0;
  logic          rst_n, sdclk, sddat0, rstart;
  logic          rbusy, rdone, crc_ok, rtimeout, rbyte_we, sd_d0_dir;
  logic [7:0]    rbyte;
  logic [AW-1:0] rbyte_addr;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         we_cnt   = 0;
  int         done_cnt = 0;
  logic       prev_done = 1'b0;
  int         half = 2;
  logic [7:0] pay [BB];

  sd_block_reader #(.BLOCK_BYTES(BB), .TIMEOUT_EDGES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sdclk(sdclk), .sddat0(sddat0), .rstart(rstart),
    .rbusy(rbusy), .rdone(rdone), .crc_ok(crc_ok), .rtimeout(rtimeout),
    .rbyte(rbyte), .rbyte_we(rbyte_we), .rbyte_addr(rbyte_addr), .SD_D0_DIR(sd_d0_dir)
  );

  always #5 clk = ~clk;

  // Strobe/pulse monitor sampled just after each active edge.
  always begin
    @(posedge clk);
    #1;
    if (rbyte_we === 1'b1) we_cnt++;
    if (rdone === 1'b1) begin
      done_cnt++;
      n_assert++;
      assert (prev_done === 1'b0 && rbusy === 1'b0) else begin
        n_fail++;
        $error("FAIL rdone_pulse: prev_rdone=%b rbusy=%b, expected 0/0", prev_done, rbusy);
      end
    end
    prev_done = rdone;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC16-CCITT computed bytewise over the payload.
  function automatic logic [15:0] model_crc();
    logic [15:0] c;
    c = 16'h0000;
    for (int i = 0; i < BB; i++) begin
      c = c ^ {pay[i], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // One sdclk period; DAT0 is noisy while sdclk is low and settles before the rise.
  task automatic send_bit(input logic b, input bit chk_byte, input int idx);
    sdclk  = 1'b0;
    sddat0 = 1'($urandom);
    repeat (half) @(negedge clk);
    sddat0 = b;
    sdclk  = 1'b1;
    @(negedge clk);
    if (chk_byte) begin
      chk("we_latency", 32'(rbyte_we), 32'd1);
      chk("rbyte", 32'(rbyte), 32'(pay[idx]));
      chk("rbyte_addr", 32'(rbyte_addr), 32'(idx));
    end
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic pulse_rstart();
    rstart = 1'b1;
    @(negedge clk);
    rstart = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit exp_ok, input bit exp_to,
                           input bit chain, input int d0);
    int n;
    n = 0;
    while (rdone !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("rdone_seen", 32'(rdone), 32'd1);
    chk("crc_ok", 32'(crc_ok), 32'(exp_ok));
    chk("rtimeout", 32'(rtimeout), 32'(exp_to));
    chk("rbusy_at_done", 32'(rbusy), 32'd0);
    chk("rdone_count", 32'(done_cnt - d0), 32'd1);
    if (chain) begin
      pulse_rstart();
      chk("chain_rbusy", 32'(rbusy), 32'd1);
      chk("chain_crc_ok_clr", 32'(crc_ok), 32'd0);
    end else begin
      repeat (3) @(negedge clk);
      chk("crc_ok_hold", 32'(crc_ok), 32'(exp_ok));
      chk("rtimeout_hold", 32'(rtimeout), 32'(exp_to));
      chk("rdone_once", 32'(done_cnt - d0), 32'd1);
    end
  endtask

  task automatic run_block(input bit do_start, input int idle_bits, input logic [15:0] crc_tx,
                           input logic endb, input int rstart_at, input int rst_at,
                           input bit exp_ok, input bit chain);
    int we0, d0;
    we0 = we_cnt;
    d0  = done_cnt;
    if (do_start) pulse_rstart();
    repeat (idle_bits) send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    for (int i = 0; i < BB; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rbusy", 32'(rbusy), 32'd0);
        chk("rst_rdone", 32'(rdone), 32'd0);
        chk("rst_crc_ok", 32'(crc_ok), 32'd0);
        chk("rst_rtimeout", 32'(rtimeout), 32'd0);
        chk("rst_rbyte", 32'(rbyte), 32'd0);
        chk("rst_rbyte_we", 32'(rbyte_we), 32'd0);
        chk("rst_rbyte_addr", 32'(rbyte_addr), 32'd0);
        chk("rst_we_count", 32'(we_cnt - we0), 32'(rst_at));
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_rdone", 32'(done_cnt - d0), 32'd0);
        return;
      end
      if (i == rstart_at) begin
        chk("rbusy_mid", 32'(rbusy), 32'd1);
        pulse_rstart();
      end
      for (int k = 7; k >= 0; k--) send_bit(pay[i][k], k == 0, i);
    end
    for (int k = 15; k >= 0; k--) send_bit(crc_tx[k], 1'b0, 0);
    send_bit(endb, 1'b0, 0);
    chk("we_count", 32'(we_cnt - we0), 32'(BB));
    wait_done(8, exp_ok, 1'b0, chain, d0);
  endtask

  initial begin
    int d0, we0;
    rst_n  = 1'b0;
    sdclk  = 1'b0;
    sddat0 = 1'b1;
    rstart = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_rbusy", 32'(rbusy), 32'd0);
    chk("init_rdone", 32'(rdone), 32'd0);
    chk("init_crc_ok", 32'(crc_ok), 32'd0);
    chk("init_rtimeout", 32'(rtimeout), 32'd0);
    chk("init_rbyte", 32'(rbyte), 32'd0);
    chk("init_rbyte_we", 32'(rbyte_we), 32'd0);
    chk("init_rbyte_addr", 32'(rbyte_addr), 32'd0);
    chk("d0_dir", 32'(sd_d0_dir), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-0xFF block at sdclk = clk/4 with its well-known CRC.
    half = 2;
    for (int i = 0; i < BB; i++) pay[i] = 8'hFF;
    run_block(1'b1, 20, 16'h7FA1, 1'b1, -1, -1, 1'b1, 1'b0);

    // Faster sdclk from here on to keep the run short.
    half = 1;
    for (int i = 0; i < BB; i++) pay[i] = 8'(i);
    run_block(1'b1, $urandom_range(0, 30), model_crc(), 1'b1, 40, -1, 1'b1, 1'b0);

    for (int i = 0; i < BB; i++) pay[i] = 8'hFF;
    run_block(1'b1, $urandom_range(0, 30), 16'h7FA0, 1'b1, -1, -1, 1'b0, 1'b0);

    for (int i = 0; i < BB; i++) pay[i] = 8'($urandom);
    run_block(1'b1, $urandom_range(0, 30), model_crc(), 1'b0, -1, -1, 1'b0, 1'b0);

    // Start-bit timeout with DAT0 held high.
    d0  = done_cnt;
    we0 = we_cnt;
    pulse_rstart();
    repeat (TO - 1) send_bit(1'b1, 1'b0, 0);
    chk("to_not_yet", 32'(done_cnt - d0), 32'd0);
    chk("to_rbusy", 32'(rbusy), 32'd1);
    send_bit(1'b1, 1'b0, 0);
    wait_done(2, 1'b0, 1'b1, 1'b0, d0);
    chk("to_no_we", 32'(we_cnt - we0), 32'd0);

    // Reset in the middle of a block.
    for (int i = 0; i < BB; i++) pay[i] = 8'($urandom);
    pay[99] = 8'hA5;
    run_block(1'b1, $urandom_range(0, 30), model_crc(), 1'b1, -1, 100, 1'b0, 1'b0);

    // Full block after reset, chained into an all-zero block from the rdone cycle.
    for (int i = 0; i < BB; i++) pay[i] = 8'($urandom);
    run_block(1'b1, $urandom_range(0, 30), model_crc(), 1'b1, -1, -1, 1'b1, 1'b1);
    for (int i = 0; i < BB; i++) pay[i] = 8'h00;
    run_block(1'b0, $urandom_range(0, 30), 16'h0000, 1'b1, -1, -1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
